// File: rtl/permute_controller_3.sv
// Sequencing FSM for the 25-bit permute datapath: per line it runs load -> permute -> write,
// framed by a start/done handshake.
module permute_controller_3 #(
  parameter int unsigned LINES  = 64,
  parameter int unsigned CNT_W  = 7,
  parameter int unsigned ROUNDS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             line_valid,
  input  logic             write_ready,
  input  logic [CNT_W-1:0] cnt_value,
  input  logic             counter_co,
  output logic             read_en,
  output logic             mux_en,
  output logic             reg_en,
  output logic             reg_rst,
  output logic             permute_en,
  output logic             write_en,
  output logic             cnt_64_en,
  output logic             line_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StLoad,
    StPerm,
    StWrite,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] LastLine  = CNT_W'(LINES - 1);
  localparam logic [3:0]       LastRound = 4'(ROUNDS - 1);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    read_en    = 1'b0;
    mux_en     = 1'b0;
    reg_en     = 1'b0;
    reg_rst    = 1'b0;
    permute_en = 1'b0;
    write_en   = 1'b0;
    cnt_64_en  = 1'b0;
    line_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy    = 1'b0;
        reg_rst = 1'b1;
        if (start) begin
          state_d = (cnt_value == '0) ? StLoad : StAlign;
        end
      end
      // Walk the datapath counter up to its wrap so every frame starts at line 0.
      StAlign: begin
        cnt_64_en = 1'b1;
        if (counter_co) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        read_en    = 1'b1;
        line_ready = 1'b1;
        reg_en     = line_valid;
        if (line_valid) begin
          round_d = '0;
          state_d = StPerm;
        end
      end
      StPerm: begin
        mux_en     = 1'b1;
        permute_en = 1'b1;
        reg_en     = 1'b1;
        round_d    = round_q + 4'd1;
        if (round_q == LastRound) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        write_en  = 1'b1;
        cnt_64_en = write_ready;
        if (write_ready) begin
          state_d = (cnt_value == LastLine) ? StDone : StLoad;
        end
      end
      StDone: begin
        done    = 1'b1;
        reg_rst = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_permute_controller_3.sv
// Bench for permute_controller_3: two instances (ROUNDS=1 and ROUNDS=3), each with a modelled
// datapath line counter, checked by directed steps and a load/write scoreboard.
module tb_permute_controller_3;

  localparam int unsigned CNT_W = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic line_valid = 1'b0;
  logic write_ready = 1'b0;
  logic [CNT_W-1:0] cnt_a = '0;
  logic [CNT_W-1:0] cnt_b = '0;
  logic co_a, co_b;

  logic read_en_a, mux_en_a, reg_en_a, reg_rst_a, permute_en_a, write_en_a;
  logic cnt_64_en_a, line_ready_a, busy_a, done_a;
  logic read_en_b, mux_en_b, reg_en_b, reg_rst_b, permute_en_b, write_en_b;
  logic cnt_64_en_b, line_ready_b, busy_b, done_b;

  always #5 clk = ~clk;

  assign co_a = &cnt_a;
  assign co_b = &cnt_b;

  permute_controller_3 #(.LINES(64), .CNT_W(CNT_W), .ROUNDS(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .line_valid(line_valid), .write_ready(write_ready),
    .cnt_value(cnt_a), .counter_co(co_a), .read_en(read_en_a), .mux_en(mux_en_a),
    .reg_en(reg_en_a), .reg_rst(reg_rst_a), .permute_en(permute_en_a), .write_en(write_en_a),
    .cnt_64_en(cnt_64_en_a), .line_ready(line_ready_a), .busy(busy_a), .done(done_a)
  );

  permute_controller_3 #(.LINES(64), .CNT_W(CNT_W), .ROUNDS(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .line_valid(line_valid), .write_ready(write_ready),
    .cnt_value(cnt_b), .counter_co(co_b), .read_en(read_en_b), .mux_en(mux_en_b),
    .reg_en(reg_en_b), .reg_rst(reg_rst_b), .permute_en(permute_en_b), .write_en(write_en_b),
    .cnt_64_en(cnt_64_en_b), .line_ready(line_ready_b), .busy(busy_b), .done(done_b)
  );

  // Output vector bits: 9 read_en, 8 mux_en, 7 reg_en, 6 reg_rst, 5 permute_en,
  // 4 write_en, 3 cnt_64_en, 2 line_ready, 1 busy, 0 done.
  localparam logic [9:0] OIdle  = 10'h040;
  localparam logic [9:0] OAlign = 10'h00A;
  localparam logic [9:0] OLoad  = 10'h206;
  localparam logic [9:0] OLoadV = 10'h286;
  localparam logic [9:0] OPerm  = 10'h1A2;
  localparam logic [9:0] OWait  = 10'h012;
  localparam logic [9:0] OWrite = 10'h01A;
  localparam logic [9:0] ODone  = 10'h043;

  int n_checks = 0;
  int n_err = 0;
  bit sel = 1'b0;
  logic [9:0] obs;
  logic [CNT_W-1:0] o_cnt;
  int perm_run = 0;
  int n_writes = 0;
  int n_cnt_en = 0;
  logic [CNT_W-1:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] pack_a();
    return {read_en_a, mux_en_a, reg_en_a, reg_rst_a, permute_en_a, write_en_a,
            cnt_64_en_a, line_ready_a, busy_a, done_a};
  endfunction

  function automatic logic [9:0] pack_b();
    return {read_en_b, mux_en_b, reg_en_b, reg_rst_b, permute_en_b, write_en_b,
            cnt_64_en_b, line_ready_b, busy_b, done_b};
  endfunction

  // One clock: sample at negedge, score the selected DUT, then advance the counter models.
  task automatic step();
    logic en_a, en_b;
    logic [CNT_W-1:0] exp_line;
    @(negedge clk);
    en_a  = cnt_64_en_a;
    en_b  = cnt_64_en_b;
    obs   = sel ? pack_b() : pack_a();
    o_cnt = sel ? cnt_b : cnt_a;
    if (obs[9] && obs[2] && line_valid) begin
      sb_q.push_back(o_cnt);
      perm_run = 0;
    end
    if (obs[5]) begin
      perm_run++;
      check("perm_outputs", 32'(obs), 32'(OPerm));
    end
    if (obs[3]) begin
      n_cnt_en++;
      check("cnt_en_state", 32'(obs & 10'h2A1), 32'd0);
    end
    if (obs[4] && write_ready) begin
      n_writes++;
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        exp_line = sb_q.pop_front();
        check("sb_line", 32'(o_cnt), 32'(exp_line));
        check("sb_rounds", 32'(perm_run), sel ? 32'd3 : 32'd1);
      end
    end
    @(posedge clk);
    #1;
    if (en_a) cnt_a = cnt_a + 1'b1;
    if (en_b) cnt_b = cnt_b + 1'b1;
  endtask

  task automatic run_to_done(input int limit, input bit toggle, output int n);
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < limit) begin
      if (toggle) start = ~start;
      step();
      n++;
      if (obs[0]) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    check("done_outputs", 32'(obs), 32'(ODone));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int align_n;

    // Reset state
    #2;
    check("reset_outputs_a", 32'(pack_a()), 32'(OIdle));
    check("reset_outputs_b", 32'(pack_b()), 32'(OIdle));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Aligned frame, no stalls, ROUNDS=1
    sel = 1'b0;
    cnt_a = '0;
    start = 1'b1; line_valid = 1'b1; write_ready = 1'b1;
    n_writes = 0; n_cnt_en = 0;
    step();
    check("t2_idle", 32'(obs), 32'(OIdle));
    start = 1'b0;
    run_to_done(400, 1'b0, n);
    check("t2_latency", 32'(n), 32'd193);
    check("t2_writes", 32'(n_writes), 32'd64);
    check("t2_cnt_en", 32'(n_cnt_en), 32'd64);
    step();
    check("t2_back_idle", 32'(obs), 32'(OIdle));

    // Upstream stall then downstream backpressure within one frame
    cnt_a = '0;
    start = 1'b1; line_valid = 1'b0; write_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_load_stall", 32'(obs), 32'(OLoad));
    end
    line_valid = 1'b1;
    step();
    check("t3_load_accept", 32'(obs), 32'(OLoadV));
    step();
    step();
    check("t3_write", 32'(obs), 32'(OWrite));
    step();
    check("t4_load", 32'(obs), 32'(OLoadV));
    write_ready = 1'b0;
    step();
    n_cnt_en = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_write_hold", 32'(obs), 32'(OWait));
    end
    write_ready = 1'b1;
    step();
    check("t4_write_go", 32'(obs), 32'(OWrite));
    check("t4_single_cnt_en", 32'(n_cnt_en), 32'd1);
    run_to_done(400, 1'b0, n);
    check("t4_rest_latency", 32'(n), 32'd187);
    check("t4_cnt_left", 32'(cnt_a), 32'd64);

    // Re-align from counter value 64
    start = 1'b1;
    step();
    check("t5_idle", 32'(obs), 32'(OIdle));
    start = 1'b0;
    align_n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (obs == OAlign) align_n++;
      else break;
    end
    check("t5_align_cycles", 32'(align_n), 32'd64);
    check("t5_load_cnt", 32'(o_cnt), 32'd0);
    check("t5_load_outputs", 32'(obs), 32'(OLoadV));
    run_to_done(400, 1'b0, n);
    check("t5_latency", 32'(n), 32'd192);

    // Mid-PERM asynchronous reset on the ROUNDS=3 instance
    rst = 1'b0;
    step();
    rst = 1'b1;
    sb_q.delete();
    sel = 1'b1;
    cnt_b = '0;
    start = 1'b1; line_valid = 1'b1; write_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t1_load", 32'(obs), 32'(OLoadV));
    step();
    rst = 1'b0;
    #2;
    check("t1_async_reset", 32'(pack_b()), 32'(OIdle));
    step();
    check("t1_reset_hold", 32'(obs), 32'(OIdle));
    rst = 1'b1;
    step();
    check("t1_idle_no_done", 32'(obs), 32'(OIdle));
    sb_q.delete();

    // ROUNDS=3 frame with start toggled while busy
    cnt_b = '0;
    start = 1'b1;
    n_writes = 0;
    step();
    run_to_done(600, 1'b1, n);
    check("t6_latency", 32'(n), 32'd321);
    check("t6_writes", 32'(n_writes), 32'd64);
    check("t6_sb_drained", 32'(sb_q.size()), 32'd0);
    start = 1'b1;
    step();
    check("t6_idle_after_done", 32'(obs), 32'(OIdle));
    step();
    check("t6_restart_align", 32'(obs), 32'(OAlign));
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
